// File: rtl/buffet_fill_ctrl_pkg.sv
// Shared constants, default parameters and state encoding for the buffet fill sequencer.
package buffet_fill_ctrl_pkg;

  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned WORD_BYTES     = 4;

  localparam int unsigned DefIdxWidth = 8;
  localparam int unsigned DefBufDepth = 256;
  localparam int unsigned DefLenWidth = 16;
  localparam int unsigned DefTimeout  = 1024;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StWaitCr = 3'd1;
  localparam state_t StIssue  = 3'd2;
  localparam state_t StWaitRd = 3'd3;
  localparam state_t StPush   = 3'd4;
  localparam state_t StErr    = 3'd5;

endpackage

// File: rtl/buffet_fill_ctrl_credit_counter.sv
// Saturating buffet credit counter: reserve on issue, return on error, add freed slots.
module buffet_fill_ctrl_credit_counter
  import buffet_fill_ctrl_pkg::*;
#(
  parameter int unsigned IDX_WIDTH = DefIdxWidth,
  parameter int unsigned BUF_DEPTH = DefBufDepth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reserve_i,
  input  logic                 return_i,
  input  logic                 credit_valid_i,
  input  logic [IDX_WIDTH-1:0] credit_i,
  output logic [IDX_WIDTH:0]   credit_o
);

  // Two bits of headroom so cur + return + credit_in can never wrap before saturation.
  localparam int unsigned SumW = IDX_WIDTH + 2;
  localparam logic [SumW-1:0] Depth = SumW'(BUF_DEPTH);

  logic [IDX_WIDTH:0] credit_q, credit_d;
  logic [SumW-1:0]    sum;

  // Next credit count; a reserve only happens with credit_q > 0, so no underflow.
  always_comb begin
    sum = SumW'(credit_q) + SumW'(return_i) - SumW'(reserve_i);
    if (credit_valid_i) begin
      sum = sum + SumW'(credit_i);
    end
    credit_d = (sum > Depth) ? Depth[IDX_WIDTH:0] : sum[IDX_WIDTH:0];
  end

  // Credit register, full buffet on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credit_q <= Depth[IDX_WIDTH:0];
    end else begin
      credit_q <= credit_d;
    end
  end

  assign credit_o = credit_q;

endmodule

// File: rtl/buffet_fill_ctrl.sv
// Fill sequencer: reads a contiguous run of words via single-beat reads and pushes them
// into the buffet, issuing a read only after a buffet slot has been reserved.
module buffet_fill_ctrl
  import buffet_fill_ctrl_pkg::*;
#(
  parameter int unsigned IDX_WIDTH = DefIdxWidth,
  parameter int unsigned BUF_DEPTH = DefBufDepth,
  parameter int unsigned LEN_WIDTH = DefLenWidth,
  parameter int unsigned TIMEOUT   = DefTimeout
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [31:0]               cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]      cmd_len_i,
  output logic                      rd_req_o,
  output logic [31:0]               rd_addr_o,
  input  logic                      rd_done_i,
  input  logic [AXI_DATA_WIDTH-1:0] rd_data_i,
  input  logic                      rd_err_i,
  output logic [AXI_DATA_WIDTH-1:0] push_data_o,
  output logic                      push_valid_o,
  input  logic                      push_ready_i,
  input  logic [IDX_WIDTH-1:0]      credit_in_i,
  input  logic                      credit_in_valid_i,
  output logic                      credit_in_ready_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [LEN_WIDTH-1:0]      words_left_o
);

  localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Leave WAIT_RD when the incremented count would reach TIMEOUT-1.
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 2);

  state_t                      state_q, state_d;
  logic [31:0]                 addr_q, addr_d;
  logic [LEN_WIDTH-1:0]        len_q, len_d;
  logic [AXI_DATA_WIDTH-1:0]   data_q, data_d;
  logic [TmoW-1:0]             tmo_q, tmo_d;
  logic                        err_q, err_d;
  logic                        done_q, done_d;
  // Low during reset and the first cycle after, so the handshakes stay closed until then.
  logic                        live_q;
  logic [IDX_WIDTH:0]          credits;

  buffet_fill_ctrl_credit_counter #(
    .IDX_WIDTH (IDX_WIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_credit_counter (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .reserve_i      (state_q == StIssue),
    .return_i       (state_q == StErr),
    .credit_valid_i (credit_in_valid_i && live_q),
    .credit_i       (credit_in_i),
    .credit_o       (credits)
  );

  // Sequencer next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_o) begin
          addr_d = cmd_addr_i;
          len_d  = cmd_len_i;
          err_d  = 1'b0;
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StWaitCr;
          end
        end
      end
      StWaitCr: begin
        if (credits != '0) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        tmo_d   = '0;
        state_d = StWaitRd;
      end
      StWaitRd: begin
        if (rd_done_i) begin
          if (rd_err_i) begin
            state_d = StErr;
          end else begin
            data_d  = rd_data_i;
            state_d = StPush;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TmoLast) begin
            state_d = StErr;
          end
        end
      end
      StPush: begin
        if (push_ready_i) begin
          len_d  = len_q - 1'b1;
          addr_d = addr_q + 32'(WORD_BYTES);
          if (len_q == LEN_WIDTH'(1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StWaitCr;
          end
        end
      end
      StErr: begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      done_q  <= done_d;
      live_q  <= 1'b1;
    end
  end

  // Outputs decoded from state and registers.
  always_comb begin
    cmd_ready_o       = (state_q == StIdle) && live_q;
    credit_in_ready_o = live_q;
    rd_req_o          = (state_q == StIssue);
    rd_addr_o         = addr_q;
    push_valid_o      = (state_q == StPush);
    push_data_o       = data_q;
    busy_o            = (state_q != StIdle);
    done_o            = done_q;
    err_o             = err_q;
    words_left_o      = len_q;
  end

endmodule
